// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register, ID-stage read ports and the writeback register file.
interface wb_regfile_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 32
);
  logic [DW-1:0]    wb_mem_data;
  logic [DW-1:0]    wb_alu_result;
  logic [DW-1:0]    wb_pc_plus4;
  logic             wb_mem_to_reg;
  logic             wb_jal;
  logic [4:0]       wb_writereg;
  logic             wb_reg_write_final;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [DW-1:0]    id_rs_data;
  logic [DW-1:0]    id_rt_data;
  logic [DW-1:0]    wb_write_data;
  logic [CNT_W-1:0] wb_commit_count;

  modport master (
    output wb_mem_data, wb_alu_result, wb_pc_plus4, wb_mem_to_reg, wb_jal,
           wb_writereg, wb_reg_write_final, id_rs, id_rt,
    input  id_rs_data, id_rt_data, wb_write_data, wb_commit_count
  );

  modport slave (
    input  wb_mem_data, wb_alu_result, wb_pc_plus4, wb_mem_to_reg, wb_jal,
           wb_writereg, wb_reg_write_final, id_rs, id_rt,
    output id_rs_data, id_rt_data, wb_write_data, wb_commit_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback select, 32x32 register file with two async read ports and a commit counter.
// Optional write-through bypass on the read ports: define WB_REGFILE_BYPASS_EN.
module wb_regfile #(
  parameter int NREG  = 32,
  parameter int DW    = 32,
  parameter int CNT_W = 32
) (
  input logic         clk,
  input logic         reset,
  wb_regfile_if.slave bus
);

  logic [DW-1:0]    regs [NREG];
  logic [DW-1:0]    wdata;
  logic             we;
  logic [CNT_W-1:0] commit_cnt;
  logic [DW-1:0]    rs_data;
  logic [DW-1:0]    rt_data;

  // jal wins over load data: the link value must never be replaced by a load
  always_comb begin
    if (bus.wb_jal)             wdata = bus.wb_pc_plus4;
    else if (bus.wb_mem_to_reg) wdata = bus.wb_mem_data;
    else                        wdata = bus.wb_alu_result;
  end

  assign we = bus.wb_reg_write_final && (bus.wb_writereg != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      commit_cnt <= '0;
    end else if (we) begin
      regs[bus.wb_writereg] <= wdata;
      commit_cnt            <= commit_cnt + 1'b1;
    end
  end

  always_comb begin
    rs_data = (bus.id_rs == 5'd0) ? '0 : regs[bus.id_rs];
    rt_data = (bus.id_rt == 5'd0) ? '0 : regs[bus.id_rt];
`ifdef WB_REGFILE_BYPASS_EN
    // Bypass is suppressed during reset so reads show the stored contents
    if (we && !reset && (bus.id_rs == bus.wb_writereg)) rs_data = wdata;
    if (we && !reset && (bus.id_rt == bus.wb_writereg)) rt_data = wdata;
`endif
  end

  assign bus.id_rs_data      = rs_data;
  assign bus.id_rt_data      = rt_data;
  assign bus.wb_write_data   = wdata;
  assign bus.wb_commit_count = commit_cnt;

endmodule
